// File: rtl/dut_test_seq.sv
// Test-run sequencer: issues one SETUP_MUXES command, streams vectors from RAM to STIM_FIFO, waits for results.
// Optional watchdog enabled by defining DUT_TEST_SEQ_TIMEOUT_EN.
module dut_test_seq #(
   parameter int STF_WIDTH      = 24,
   parameter int CMD_EXT_WIDTH  = 8,
   parameter int DIF_WIDTH      = 32,
   parameter int ADDR_WIDTH     = 10,
   parameter int CNT_WIDTH      = 16,
   parameter int TIMEOUT_CYCLES = 4096
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  start,
   input  logic [STF_WIDTH-1:0]  cfg_mux,
   input  logic [ADDR_WIDTH-1:0] cfg_base,
   input  logic [CNT_WIDTH-1:0]  cfg_count,
   output logic                  busy,
   output logic                  done,
   output logic                  err,
   output logic [ADDR_WIDTH-1:0] vmem_addr,
   output logic                  vmem_rden,
   input  logic [STF_WIDTH-1:0]  vmem_q,
   output logic [DIF_WIDTH-1:0]  dififo_data,
   output logic                  dififo_wrreq,
   input  logic                  dififo_wrfull,
   output logic [STF_WIDTH-1:0]  sfifo_data,
   output logic                  sfifo_wrreq,
   input  logic                  sfifo_wrfull,
   input  logic                  res_tick
);

   localparam logic [CMD_EXT_WIDTH-1:0] CMD_SETUP_MUXES = CMD_EXT_WIDTH'(1);

   typedef enum logic [2:0] {S_IDLE, S_CFG, S_STREAM, S_DRAIN, S_FIN} state_t;

   state_t                r_state, w_next;
   logic [STF_WIDTH-1:0]  r_mux;
   logic [ADDR_WIDTH-1:0] r_addr;
   logic [CNT_WIDTH-1:0]  r_count, r_issued, r_written, r_results;
   logic                  r_pend;
   logic                  r_skid_vld;
   logic [STF_WIDTH-1:0]  r_skid_data;
   logic                  w_busy, w_rd, w_swr, w_tick, w_timeout, w_accept;
   logic [STF_WIDTH-1:0]  w_sdata;
   logic [DIF_WIDTH-1:0]  w_dif;

   always_comb begin
      w_busy   = (r_state == S_CFG) || (r_state == S_STREAM) || (r_state == S_DRAIN);
      w_accept = (r_state == S_IDLE) && start;
      // A read is only issued when its data is guaranteed a free slot (FIFO or skid).
      w_rd     = (r_state == S_STREAM) && (r_issued != r_count) && !sfifo_wrfull && !r_skid_vld;
      w_swr    = (r_state == S_STREAM) && (r_skid_vld || r_pend) && !sfifo_wrfull;
      w_tick   = res_tick && w_busy && (r_results != r_count);
      w_sdata  = '0;
      if (r_skid_vld)
         w_sdata = r_skid_data;
      else if (r_pend)
         w_sdata = vmem_q;
      w_dif    = '0;
      if (r_state == S_CFG) begin
         w_dif[STF_WIDTH-1:0]                 = r_mux;
         w_dif[DIF_WIDTH-1 -: CMD_EXT_WIDTH]  = CMD_SETUP_MUXES;
      end
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:   if (start) w_next = S_CFG;
         S_CFG:    if (!dififo_wrfull) w_next = S_STREAM;
         S_STREAM: begin
            if (w_timeout)
               w_next = S_FIN;
            else if (r_written == r_count)
               w_next = (r_results == r_count) ? S_FIN : S_DRAIN;
         end
         S_DRAIN:  if (w_timeout || (r_results == r_count)) w_next = S_FIN;
         S_FIN:    w_next = S_IDLE;
         default:  w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_state     <= S_IDLE;
         r_mux       <= '0;
         r_addr      <= '0;
         r_count     <= '0;
         r_issued    <= '0;
         r_written   <= '0;
         r_results   <= '0;
         r_pend      <= 1'b0;
         r_skid_vld  <= 1'b0;
         r_skid_data <= '0;
      end else begin
         r_state <= w_next;
         if (w_accept) begin
            r_mux      <= cfg_mux;
            r_addr     <= cfg_base;
            r_count    <= cfg_count;
            r_issued   <= '0;
            r_written  <= '0;
            r_results  <= '0;
            r_pend     <= 1'b0;
            r_skid_vld <= 1'b0;
         end else begin
            r_pend <= w_rd && !w_timeout;
            if (w_rd) begin
               r_addr   <= r_addr + 1'b1;
               r_issued <= r_issued + 1'b1;
            end
            if (w_swr)
               r_written <= r_written + 1'b1;
            if (w_tick)
               r_results <= r_results + 1'b1;
            if (w_timeout)
               r_skid_vld <= 1'b0;
            else if (r_skid_vld && w_swr)
               r_skid_vld <= 1'b0;
            else if (r_pend && sfifo_wrfull && (r_state == S_STREAM)) begin
               r_skid_vld  <= 1'b1;
               r_skid_data <= vmem_q;
            end
         end
      end
   end

`ifdef DUT_TEST_SEQ_TIMEOUT_EN
   localparam int WD_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

   logic [WD_W-1:0] r_wdog;
   logic            r_err;

   // Counts consecutive idle cycles; any result tick or vector write restarts it.
   assign w_timeout = ((r_state == S_STREAM) || (r_state == S_DRAIN)) && !res_tick && !w_swr &&
                      (r_wdog == WD_W'(TIMEOUT_CYCLES - 1));

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_wdog <= '0;
         r_err  <= 1'b0;
      end else begin
         if (w_accept)
            r_err <= 1'b0;
         else if (w_timeout)
            r_err <= 1'b1;
         if (((r_state == S_STREAM) || (r_state == S_DRAIN)) && !res_tick && !w_swr && !w_timeout)
            r_wdog <= r_wdog + 1'b1;
         else
            r_wdog <= '0;
      end
   end

   assign err = r_err;
`else
   assign w_timeout = 1'b0;
   assign err       = 1'b0;
`endif

   assign busy         = w_busy;
   assign done         = (r_state == S_FIN);
   assign vmem_addr    = r_addr;
   assign vmem_rden    = w_rd;
   assign dififo_data  = w_dif;
   assign dififo_wrreq = (r_state == S_CFG) && !dififo_wrfull;
   assign sfifo_data   = w_sdata;
   assign sfifo_wrreq  = w_swr;

endmodule

// File: tb/tb_dut_test_seq.sv
// Bench for dut_test_seq: RAM/FIFO environment model, random back-pressure, scenario tasks.
module tb_dut_test_seq;
   logic        clock = 1'b0, reset = 1'b1, start = 1'b0;
   logic [23:0] cfg_mux = '0;
   logic [9:0]  cfg_base = '0;
   logic [15:0] cfg_count = '0;
   logic        busy, done, err, vmem_rden, dififo_wrreq, sfifo_wrreq;
   logic [9:0]  vmem_addr;
   logic [23:0] vmem_q = '0, sfifo_data;
   logic [31:0] dififo_data;
   logic        dififo_wrfull = 1'b0, sfifo_wrfull = 1'b0, res_tick = 1'b0;

   int errors = 0, checks = 0, cyc = 0;
   logic [23:0] ram [0:1023];
   logic [23:0] q_stim[$];
   logic [31:0] q_dif[$];
   logic [9:0]  q_addr[$];
   int          stim_cyc[$];
   int          done_cnt = 0, viol = 0, done_cyc = 0, last_act = 0, start_cyc = 0;

   dut_test_seq #(.TIMEOUT_CYCLES(16)) u_dut (
      .clock(clock), .reset(reset), .start(start), .cfg_mux(cfg_mux), .cfg_base(cfg_base),
      .cfg_count(cfg_count), .busy(busy), .done(done), .err(err), .vmem_addr(vmem_addr),
      .vmem_rden(vmem_rden), .vmem_q(vmem_q), .dififo_data(dififo_data),
      .dififo_wrreq(dififo_wrreq), .dififo_wrfull(dififo_wrfull), .sfifo_data(sfifo_data),
      .sfifo_wrreq(sfifo_wrreq), .sfifo_wrfull(sfifo_wrfull), .res_tick(res_tick));

   always #5 clock = ~clock;
   always @(posedge clock) cyc++;
   always @(posedge clock) if (vmem_rden) vmem_q <= ram[vmem_addr];

   always @(negedge clock) begin
      if (!reset) begin
         if (sfifo_wrreq) begin
            q_stim.push_back(sfifo_data);
            stim_cyc.push_back(cyc);
            if (sfifo_wrfull) viol++;
         end
         if (dififo_wrreq) begin
            q_dif.push_back(dififo_data);
            if (dififo_wrfull) viol++;
         end
         if (vmem_rden) q_addr.push_back(vmem_addr);
         if (sfifo_wrreq || res_tick) last_act = cyc;
         if (done) begin
            done_cnt++;
            done_cyc = cyc;
         end
      end
   end

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   // Drives one run to completion (or budget); no checking here.
   task automatic do_run(input logic [9:0] base, input int cnt, input logic [23:0] mux,
                         input int full_pct, input int tick_pct, input int ticks,
                         input int hold_after, input int restart_at, input int budget);
      int sent, n, hold_left;
      bit hold_started;
      q_stim.delete(); q_dif.delete(); q_addr.delete(); stim_cyc.delete();
      done_cnt = 0; viol = 0; sent = 0; n = 0; hold_left = 0; hold_started = 0;
      cfg_base = base; cfg_count = 16'(cnt); cfg_mux = mux;
      start = 1'b1; start_cyc = cyc;
      step();
      start = 1'b0;
      while (done_cnt == 0 && n < budget) begin
         start = (n == restart_at);
         if (start) begin
            cfg_base = 10'd0; cfg_count = 16'd1; cfg_mux = 24'hFFFFFF;
         end
         dififo_wrfull = ($urandom_range(99) < full_pct);
         if (hold_after >= 0 && !hold_started && q_stim.size() >= hold_after) begin
            hold_started = 1; hold_left = 3;
         end
         if (hold_left > 0) begin
            sfifo_wrfull = 1'b1; hold_left--;
         end else
            sfifo_wrfull = ($urandom_range(99) < full_pct);
         res_tick = (sent < ticks) && ($urandom_range(99) < tick_pct);
         if (res_tick) sent++;
         step();
         n++;
      end
      start = 1'b0; res_tick = 1'b0; sfifo_wrfull = 1'b0; dififo_wrfull = 1'b0;
      step(); step();
   endtask

   task automatic test_reset();
      reset = 1'b1; start = 1'b1; cfg_count = 16'd3;
      step();
      checks++;
      if ({busy, done, err, vmem_rden, dififo_wrreq, sfifo_wrreq} !== 6'b0) begin
         errors++; $display("FAIL reset_ctrl got=%b want=000000",
                            {busy, done, err, vmem_rden, dififo_wrreq, sfifo_wrreq});
      end
      checks++;
      if ({vmem_addr, dififo_data, sfifo_data} !== 66'b0) begin
         errors++; $display("FAIL reset_data addr=%h dif=%h stim=%h want 0", vmem_addr, dififo_data, sfifo_data);
      end
      reset = 1'b0; start = 1'b0;
      step(); step();
      checks++;
      if (busy !== 1'b0) begin errors++; $display("FAIL start_with_reset busy=%b want=0", busy); end
   endtask

   task automatic test_basic();
      ram[0] = 24'hA0A0A1; ram[1] = 24'hB0B0B2; ram[2] = 24'hC0C0C3;
      do_run(10'd0, 3, 24'h000004, 0, 100, 3, -1, -1, 200);
      checks++;
      if (q_dif.size() != 1 || q_dif[0] !== 32'h01000004) begin
         errors++; $display("FAIL basic_dif n=%0d word=%h want 1 x 01000004", q_dif.size(), q_dif.size() ? q_dif[0] : 32'h0);
      end
      checks++;
      if (q_stim.size() != 3) begin errors++; $display("FAIL basic_count got=%0d want=3", q_stim.size()); end
      for (int i = 0; i < 3 && i < q_stim.size(); i++) begin
         checks++;
         if (q_stim[i] !== ram[i]) begin errors++; $display("FAIL basic_data[%0d] got=%h want=%h", i, q_stim[i], ram[i]); end
      end
      checks++;
      if (stim_cyc.size() == 3 && (stim_cyc[1] != stim_cyc[0] + 1 || stim_cyc[2] != stim_cyc[1] + 1)) begin
         errors++; $display("FAIL basic_consecutive cycles=%0d,%0d,%0d want consecutive", stim_cyc[0], stim_cyc[1], stim_cyc[2]);
      end
      checks++;
      if (done_cnt != 1 || err !== 1'b0 || busy !== 1'b0) begin
         errors++; $display("FAIL basic_done done=%0d err=%b busy=%b want 1,0,0", done_cnt, err, busy);
      end
   endtask

   task automatic test_skid();
      for (int r = 0; r < 4; r++) begin
         do_run(10'(r * 37), 4 + r * 5, 24'(r), (r == 0) ? 0 : 40, 50, 4 + r * 5 + 2, (r == 0) ? 2 : -1, -1, 600);
         checks++;
         if (q_stim.size() != 4 + r * 5 || viol != 0 || done_cnt != 1) begin
            errors++; $display("FAIL skid_run%0d writes=%0d viol=%0d done=%0d want %0d,0,1", r, q_stim.size(), viol, done_cnt, 4 + r * 5);
         end
         for (int i = 0; i < q_stim.size() && i < 4 + r * 5; i++) begin
            checks++;
            if (q_stim[i] !== ram[(r * 37 + i) % 1024]) begin
               errors++; $display("FAIL skid_order r%0d[%0d] got=%h want=%h", r, i, q_stim[i], ram[(r * 37 + i) % 1024]);
            end
         end
      end
   endtask

   task automatic test_wrap();
      logic [9:0] exp_a [4];
      exp_a = '{10'h3FE, 10'h3FF, 10'h000, 10'h001};
      do_run(10'h3FE, 4, 24'h123456, 0, 100, 4, -1, -1, 200);
      checks++;
      if (q_addr.size() != 4 || q_stim.size() != 4) begin
         errors++; $display("FAIL wrap_count reads=%0d writes=%0d want 4,4", q_addr.size(), q_stim.size());
      end
      for (int i = 0; i < 4 && i < q_addr.size() && i < q_stim.size(); i++) begin
         checks++;
         if (q_addr[i] !== exp_a[i] || q_stim[i] !== ram[exp_a[i]]) begin
            errors++; $display("FAIL wrap[%0d] addr=%h data=%h want %h/%h", i, q_addr[i], q_stim[i], exp_a[i], ram[exp_a[i]]);
         end
      end
   endtask

   task automatic test_zero_and_busy_start();
      do_run(10'd7, 0, 24'h00ABCD, 0, 0, 0, -1, -1, 50);
      checks++;
      if (q_dif.size() != 1 || q_stim.size() != 0 || done_cnt != 1) begin
         errors++; $display("FAIL zero_count dif=%0d stim=%0d done=%0d want 1,0,1", q_dif.size(), q_stim.size(), done_cnt);
      end
      checks++;
      if (done_cyc - start_cyc < 2 || done_cyc - start_cyc > 3) begin
         errors++; $display("FAIL zero_latency got=%0d want 2..3", done_cyc - start_cyc);
      end
      do_run(10'd5, 6, 24'h0000F0, 0, 30, 6, -1, 3, 300);
      checks++;
      if (q_dif.size() != 1 || q_dif[0] !== 32'h010000F0 || q_stim.size() != 6 || done_cnt != 1) begin
         errors++; $display("FAIL busy_start dif=%0d stim=%0d done=%0d want 1 x 010000F0,6,1", q_dif.size(), q_stim.size(), done_cnt);
      end
   endtask

   task automatic test_reset_midrun();
      int d0;
      cfg_base = 10'd0; cfg_count = 16'd40; cfg_mux = 24'h1;
      start = 1'b1; step(); start = 1'b0;
      repeat (6) step();
      d0 = done_cnt;
      reset = 1'b1;
      #1;
      checks++;
      if ({busy, done, vmem_rden, dififo_wrreq, sfifo_wrreq, vmem_addr, sfifo_data} !== 39'b0) begin
         errors++; $display("FAIL midrun_reset busy=%b rden=%b swr=%b addr=%h want all 0", busy, vmem_rden, sfifo_wrreq, vmem_addr);
      end
      repeat (3) step();
      reset = 1'b0;
      repeat (10) step();
      checks++;
      if (done_cnt != d0 || busy !== 1'b0) begin
         errors++; $display("FAIL midrun_nodone done=%0d busy=%b want %0d,0", done_cnt, busy, d0);
      end
   endtask

   task automatic test_random();
      for (int r = 0; r < 6; r++) begin
         int cnt;
         logic [9:0] base;
         cnt = $urandom_range(20, 1);
         base = 10'($urandom_range(1023));
         do_run(base, cnt, 24'($urandom), 30, 40, cnt + 2, -1, -1, 2000);
         checks++;
         if (q_stim.size() != cnt || viol != 0 || done_cnt != 1 || q_dif.size() != 1) begin
            errors++; $display("FAIL rand%0d writes=%0d viol=%0d done=%0d dif=%0d want %0d,0,1,1", r, q_stim.size(), viol, done_cnt, q_dif.size(), cnt);
         end
         for (int i = 0; i < q_stim.size() && i < cnt; i++) begin
            checks++;
            if (q_stim[i] !== ram[(int'(base) + i) % 1024]) begin
               errors++; $display("FAIL rand%0d_data[%0d] got=%h want=%h", r, i, q_stim[i], ram[(int'(base) + i) % 1024]);
            end
         end
      end
   endtask

   task automatic test_timeout();
      do_run(10'd100, 2, 24'h2, 0, 100, 1, -1, -1, 100);
`ifdef DUT_TEST_SEQ_TIMEOUT_EN
      checks++;
      if (done_cnt != 1 || err !== 1'b1) begin
         errors++; $display("FAIL timeout_err done=%0d err=%b want 1,1", done_cnt, err);
      end
      checks++;
      if (done_cyc - last_act < 16 || done_cyc - last_act > 17) begin
         errors++; $display("FAIL timeout_delay got=%0d want 16..17", done_cyc - last_act);
      end
      do_run(10'd0, 0, 24'h0, 0, 0, 0, -1, -1, 50);
      checks++;
      if (done_cnt != 1 || err !== 1'b0) begin
         errors++; $display("FAIL timeout_clear done=%0d err=%b want 1,0", done_cnt, err);
      end
`else
      checks++;
      if (done_cnt != 0 || busy !== 1'b1 || err !== 1'b0) begin
         errors++; $display("FAIL no_watchdog done=%0d busy=%b err=%b want 0,1,0", done_cnt, busy, err);
      end
      reset = 1'b1; step(); reset = 1'b0; step();
`endif
   endtask

   initial begin
      for (int i = 0; i < 1024; i++) ram[i] = 24'($urandom);
      test_reset();
      test_basic();
      test_skid();
      test_wrap();
      test_zero_and_busy_start();
      test_reset_midrun();
      test_random();
      test_timeout();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
